// File: rtl/systolic_scheduler_if.sv
// Job, operand, array and result channels between systolic_scheduler and its neighbours.
// master = scheduler side, slave = fetch path / array / result consumer side.
interface systolic_scheduler_if #(
  parameter int WIDTH     = 16,
  parameter int NUM_UNITS = 3,
  parameter int MAX_LEN   = 64
) ();
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int BUS_W = NUM_UNITS * WIDTH;

  logic                 job_valid;
  logic                 job_ready;
  logic [LEN_W-1:0]     job_len;
  logic                 op_valid;
  logic                 op_ready;
  logic [BUS_W-1:0]     op_a;
  logic [BUS_W-1:0]     op_b;
  logic                 arr_start;
  logic [NUM_UNITS-1:0] arr_active;
  logic [BUS_W-1:0]     arr_a;
  logic [BUS_W-1:0]     arr_b;
  logic [BUS_W-1:0]     arr_result;
  logic [NUM_UNITS-1:0] arr_ready;
  logic                 res_valid;
  logic                 res_ready;
  logic [BUS_W-1:0]     res_data;
  logic [NUM_UNITS-1:0] res_mask;
  logic                 res_last;
  logic                 busy;
  logic                 err;

  modport master (
    input  job_valid, job_len, op_valid, op_a, op_b, arr_result, arr_ready, res_ready,
    output job_ready, op_ready, arr_start, arr_active, arr_a, arr_b,
           res_valid, res_data, res_mask, res_last, busy, err
  );

  modport slave (
    output job_valid, job_len, op_valid, op_a, op_b, arr_result, arr_ready, res_ready,
    input  job_ready, op_ready, arr_start, arr_active, arr_a, arr_b,
           res_valid, res_data, res_mask, res_last, busy, err
  );
endinterface

// File: rtl/systolic_scheduler.sv
// Feeds one lane-wide operand beat at a time into systolic_array and streams the masked products out.
// Op accept -> arr_start 1 cycle, array ready -> res_valid 1 cycle; op_ready only in LOAD, results held under res_ready=0.
module systolic_scheduler #(
  parameter int WIDTH     = 16,
  parameter int NUM_UNITS = 3,
  parameter int MAX_LEN   = 64,
  parameter int TIMEOUT   = 255
) (
  input  logic                clk,
  input  logic                reset,
  systolic_scheduler_if.master bus
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam int BUS_W = NUM_UNITS * WIDTH;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FIRE, S_WAIT, S_OUT} state_t;

  state_t               r_state;
  logic [LEN_W-1:0]     r_remain;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_job_ready;
  logic                 r_op_ready;
  logic                 r_arr_start;
  logic                 r_res_valid;
  logic                 r_res_last;
  logic                 r_busy;
  logic                 r_err;
  logic [NUM_UNITS-1:0] r_arr_active;
  logic [NUM_UNITS-1:0] r_res_mask;
  logic [BUS_W-1:0]     r_arr_a;
  logic [BUS_W-1:0]     r_arr_b;
  logic [BUS_W-1:0]     r_res_data;

  logic [NUM_UNITS-1:0] w_beat_mask;
  logic [BUS_W-1:0]     w_res_masked;
  logic                 w_beat_last;
  logic                 w_len_bad;
  logic                 w_done;

  // r_remain counts elements not yet issued, so lane i is live while more than i remain.
  always_comb begin
    w_beat_mask  = '0;
    w_res_masked = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      w_beat_mask[i] = (r_remain > LEN_W'(i));
      if (r_arr_active[i]) begin
        w_res_masked[i*WIDTH +: WIDTH] = bus.arr_result[i*WIDTH +: WIDTH];
      end
    end
  end

  assign w_beat_last = (r_remain <= LEN_W'(NUM_UNITS));
  assign w_len_bad   = (bus.job_len == '0) || (bus.job_len > LEN_W'(MAX_LEN));
  // r_cnt==0 is the first WAIT cycle, where arr_ready may still belong to the previous op.
  assign w_done      = (r_cnt != '0) && ((bus.arr_ready & r_arr_active) == r_arr_active);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_remain     <= '0;
      r_cnt        <= '0;
      r_job_ready  <= 1'b1;
      r_op_ready   <= 1'b0;
      r_arr_start  <= 1'b0;
      r_res_valid  <= 1'b0;
      r_res_last   <= 1'b0;
      r_busy       <= 1'b0;
      r_err        <= 1'b0;
      r_arr_active <= '0;
      r_res_mask   <= '0;
      r_arr_a      <= '0;
      r_arr_b      <= '0;
      r_res_data   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.job_valid && r_job_ready) begin
            if (w_len_bad) begin
              r_err <= 1'b1;
            end else begin
              r_remain    <= bus.job_len;
              r_err       <= 1'b0;
              r_job_ready <= 1'b0;
              r_op_ready  <= 1'b1;
              r_busy      <= 1'b1;
              r_state     <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (bus.op_valid) begin
            r_arr_a      <= bus.op_a;
            r_arr_b      <= bus.op_b;
            r_arr_active <= w_beat_mask;
            r_op_ready   <= 1'b0;
            r_arr_start  <= 1'b1;
            r_state      <= S_FIRE;
          end
        end
        S_FIRE: begin
          r_arr_start <= 1'b0;
          r_cnt       <= '0;
          r_state     <= S_WAIT;
        end
        S_WAIT: begin
          if (w_done) begin
            r_res_data  <= w_res_masked;
            r_res_mask  <= r_arr_active;
            r_res_last  <= w_beat_last;
            r_res_valid <= 1'b1;
            r_state     <= S_OUT;
          end else if (r_cnt == CNT_W'(TIMEOUT)) begin
            r_err        <= 1'b1;
            r_arr_active <= '0;
            r_job_ready  <= 1'b1;
            r_busy       <= 1'b0;
            r_state      <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_OUT: begin
          if (bus.res_ready) begin
            r_res_valid <= 1'b0;
            if (r_res_last) begin
              r_arr_active <= '0;
              r_job_ready  <= 1'b1;
              r_busy       <= 1'b0;
              r_state      <= S_IDLE;
            end else begin
              r_remain   <= r_remain - LEN_W'(NUM_UNITS);
              r_op_ready <= 1'b1;
              r_state    <= S_LOAD;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.job_ready  = r_job_ready;
  assign bus.op_ready   = r_op_ready;
  assign bus.arr_start  = r_arr_start;
  assign bus.arr_active = r_arr_active;
  assign bus.arr_a      = r_arr_a;
  assign bus.arr_b      = r_arr_b;
  assign bus.res_valid  = r_res_valid;
  assign bus.res_data   = r_res_data;
  assign bus.res_mask   = r_res_mask;
  assign bus.res_last   = r_res_last;
  assign bus.busy       = r_busy;
  assign bus.err        = r_err;
endmodule

// File: tb/tb_systolic_scheduler.sv
// Bench for systolic_scheduler: a behavioural array stand-in plus per-feature scenario tasks.
module tb_systolic_scheduler;
  localparam int WIDTH     = 16;
  localparam int NUM_UNITS = 3;
  localparam int MAX_LEN   = 64;
  localparam int TIMEOUT   = 255;
  localparam int LEN_W     = $clog2(MAX_LEN + 1);
  localparam int NW        = NUM_UNITS * WIDTH;
  localparam int BOUND     = 60;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   arr_mode = 0;  // 0: ready arr_lat cycles after start, 1: always ready, 2: never ready
  int   arr_lat  = 1;
  logic [NW-1:0] last_res;

  systolic_scheduler_if #(.WIDTH(WIDTH), .NUM_UNITS(NUM_UNITS), .MAX_LEN(MAX_LEN)) bus ();

  systolic_scheduler #(
    .WIDTH(WIDTH), .NUM_UNITS(NUM_UNITS), .MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Stand-in for one FP16 multiplier lane: exact products for the known pairs, a fixed scramble otherwise.
  function automatic logic [WIDTH-1:0] arr_fn(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    if (x == 16'h4000 && y == 16'h4000) return 16'h4400;
    if (x == 16'h4200 && y == 16'h3800) return 16'h3E00;
    if (x == 16'hBC00 && y == 16'h3C00) return 16'hBC00;
    return x ^ {y[7:0], y[15:8]} ^ 16'h1357;
  endfunction

  function automatic logic [NW-1:0] arr_bus(input logic [NW-1:0] x, input logic [NW-1:0] y);
    logic [NW-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_UNITS; i++) r[i*WIDTH +: WIDTH] = arr_fn(x[i*WIDTH +: WIDTH], y[i*WIDTH +: WIDTH]);
    return r;
  endfunction

  int acnt = 0;
  bit apend = 1'b0;
  always @(negedge clk) begin
    if (arr_mode == 2) begin
      bus.arr_ready = '0;
      apend = 1'b0;
    end else if (arr_mode == 1) begin
      bus.arr_ready  = '1;
      bus.arr_result = arr_bus(bus.arr_a, bus.arr_b);
      apend = 1'b0;
    end else if (bus.arr_start === 1'b1) begin
      bus.arr_ready = '0;
      apend = 1'b1;
      acnt  = arr_lat;
    end else if (apend) begin
      if (acnt <= 1) begin
        bus.arr_ready  = '1;
        bus.arr_result = arr_bus(bus.arr_a, bus.arr_b);
        apend = 1'b0;
      end else begin
        acnt--;
      end
    end
  end

  task automatic run_job(input int len, input int lat, input bit bp, input bit fixed,
                         input logic [NW-1:0] fa, input logic [NW-1:0] fb);
    int nb, lanes, tw, nstart, exp_tw;
    logic [NW-1:0] a, b, exp_d;
    logic [NUM_UNITS-1:0] exp_m;
    nb      = (len + NUM_UNITS - 1) / NUM_UNITS;
    arr_lat = lat;
    exp_tw  = (arr_mode == 1) ? 3 : (((lat > 2) ? lat : 2) + 1);
    n_checks++;
    if (bus.job_ready !== 1'b1) begin
      n_fail++; $display("FAIL job_ready_idle: got %b expected 1", bus.job_ready);
    end
    bus.job_valid = 1'b1;
    bus.job_len   = LEN_W'(len);
    @(negedge clk);
    bus.job_valid = 1'b0;
    n_checks++;
    if ({bus.job_ready, bus.op_ready, bus.busy, bus.err} !== 4'b0110) begin
      n_fail++; $display("FAIL job_accept: {job_ready,op_ready,busy,err} got %b expected 0110",
                         {bus.job_ready, bus.op_ready, bus.busy, bus.err});
    end
    for (int bt = 0; bt < nb; bt++) begin
      lanes = len - bt * NUM_UNITS;
      if (lanes > NUM_UNITS) lanes = NUM_UNITS;
      exp_m = NUM_UNITS'((1 << lanes) - 1);
      for (int i = 0; i < NUM_UNITS; i++) begin
        a[i*WIDTH +: WIDTH] = WIDTH'($urandom);
        b[i*WIDTH +: WIDTH] = WIDTH'($urandom);
      end
      if (fixed && bt == 0) begin
        a = fa;
        b = fb;
      end
      exp_d = '0;
      for (int i = 0; i < lanes; i++) exp_d[i*WIDTH +: WIDTH] = arr_fn(a[i*WIDTH +: WIDTH], b[i*WIDTH +: WIDTH]);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      bus.op_valid = 1'b1;
      bus.op_a     = a;
      bus.op_b     = b;
      @(negedge clk);
      bus.op_valid = 1'b0;
      bus.op_a     = ~a;
      bus.op_b     = ~b;
      n_checks++;
      if ({bus.arr_start, bus.op_ready} !== 2'b10 || bus.arr_active !== exp_m) begin
        n_fail++; $display("FAIL fire beat %0d: start/op_ready %b active %b expected 10 / %b",
                           bt, {bus.arr_start, bus.op_ready}, bus.arr_active, exp_m);
      end
      tw = 0;
      nstart = 0;
      while (bus.res_valid !== 1'b1 && tw < BOUND) begin
        if (bus.arr_start === 1'b1) nstart++;
        bus.job_valid = (tw > 0) && ($urandom_range(0, 2) == 0);
        bus.job_len   = '0;
        @(negedge clk);
        tw++;
      end
      bus.job_valid = 1'b0;
      n_checks++;
      if (tw != exp_tw) begin
        n_fail++; $display("FAIL res_latency beat %0d: got %0d cycles expected %0d", bt, tw, exp_tw);
      end
      n_checks++;
      if (nstart != 1) begin
        n_fail++; $display("FAIL start_pulses beat %0d: got %0d expected 1", bt, nstart);
      end
      n_checks++;
      if (bus.arr_a !== a || bus.arr_b !== b) begin
        n_fail++; $display("FAIL arr_operands beat %0d: got %h/%h expected %h/%h", bt, bus.arr_a, bus.arr_b, a, b);
      end
      n_checks++;
      if (bus.res_data !== exp_d) begin
        n_fail++; $display("FAIL res_data beat %0d: got %h expected %h", bt, bus.res_data, exp_d);
      end
      n_checks++;
      if (bus.res_mask !== exp_m || bus.res_last !== (bt == nb - 1)) begin
        n_fail++; $display("FAIL res_mask_last beat %0d: got %b/%b expected %b/%b",
                           bt, bus.res_mask, bus.res_last, exp_m, (bt == nb - 1));
      end
      n_checks++;
      if ({bus.job_ready, bus.op_ready, bus.busy} !== 3'b001) begin
        n_fail++; $display("FAIL out_flags beat %0d: got %b expected 001", bt, {bus.job_ready, bus.op_ready, bus.busy});
      end
      last_res = bus.res_data;
      if (bp) begin
        repeat (5) begin
          bus.res_ready = 1'b0;
          @(negedge clk);
          n_checks++;
          if ({bus.res_valid, bus.op_ready, bus.arr_start} !== 3'b100 || bus.res_data !== exp_d) begin
            n_fail++; $display("FAIL backpressure_hold beat %0d: flags %b data %h expected 100 / %h",
                               bt, {bus.res_valid, bus.op_ready, bus.arr_start}, bus.res_data, exp_d);
          end
        end
      end
      bus.res_ready = 1'b1;
      @(negedge clk);
      bus.res_ready = 1'b0;
      n_checks++;
      if (bt < nb - 1) begin
        if ({bus.res_valid, bus.op_ready, bus.busy} !== 3'b011) begin
          n_fail++; $display("FAIL next_load beat %0d: got %b expected 011", bt, {bus.res_valid, bus.op_ready, bus.busy});
        end
      end else begin
        if ({bus.res_valid, bus.job_ready, bus.busy, bus.err, bus.arr_active} !== {4'b0100, {NUM_UNITS{1'b0}}}) begin
          n_fail++; $display("FAIL job_done: {res_valid,job_ready,busy,err,active} got %b expected 0100%0b",
                             {bus.res_valid, bus.job_ready, bus.busy, bus.err, bus.arr_active}, {NUM_UNITS{1'b0}});
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1 reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      bus.job_valid = 1'($urandom);
      bus.job_len   = LEN_W'($urandom);
      bus.op_valid  = 1'($urandom);
      bus.op_a      = NW'({$urandom, $urandom});
      bus.op_b      = NW'({$urandom, $urandom});
      bus.res_ready = 1'($urandom);
      @(negedge clk);
      n_checks++;
      if ({bus.job_ready, bus.op_ready, bus.arr_start, bus.res_valid, bus.busy, bus.err} !== 6'b100000 ||
          bus.arr_active !== '0 || bus.res_data !== '0) begin
        n_fail++; $display("FAIL reset_outputs cycle %0d: flags %b active %b data %h expected 100000 / 0 / 0", c,
                           {bus.job_ready, bus.op_ready, bus.arr_start, bus.res_valid, bus.busy, bus.err},
                           bus.arr_active, bus.res_data);
      end
    end
    bus.job_valid = 1'b0;
    bus.op_valid  = 1'b0;
    bus.res_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [NW-1:0] exp;
    arr_mode = 0;
    exp = {16'hBC00, 16'h3E00, 16'h4400};
    run_job(3, 3, 1'b0, 1'b1, {16'hBC00, 16'h4200, 16'h4000}, {16'h3C00, 16'h3800, 16'h4000});
    n_checks++;
    if (last_res !== exp) begin
      n_fail++; $display("FAIL single_products: got %h expected %h", last_res, exp);
    end
  endtask

  task automatic test_multi_beat();
    run_job(7, 2, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_backpressure();
    run_job(6, 4, 1'b1, 1'b0, '0, '0);
  endtask

  task automatic test_stale_ready();
    arr_mode = 1;
    run_job(4, 1, 1'b0, 1'b0, '0, '0);
    arr_mode = 0;
  endtask

  task automatic test_timeout();
    int tw;
    bit seen_res;
    arr_mode = 2;
    bus.job_valid = 1'b1;
    bus.job_len   = LEN_W'(2);
    @(negedge clk);
    bus.job_valid = 1'b0;
    bus.op_valid  = 1'b1;
    bus.op_a      = NW'({$urandom, $urandom});
    bus.op_b      = NW'({$urandom, $urandom});
    @(negedge clk);
    bus.op_valid = 1'b0;
    n_checks++;
    if (bus.arr_start !== 1'b1) begin
      n_fail++; $display("FAIL timeout_start: got %b expected 1", bus.arr_start);
    end
    tw = 0;
    seen_res = 1'b0;
    while (bus.job_ready !== 1'b1 && tw < TIMEOUT + 50) begin
      if (bus.res_valid === 1'b1) seen_res = 1'b1;
      @(negedge clk);
      tw++;
    end
    n_checks++;
    if (tw != TIMEOUT + 2) begin
      n_fail++; $display("FAIL timeout_cycles: got %0d expected %0d", tw, TIMEOUT + 2);
    end
    n_checks++;
    if ({seen_res, bus.res_valid, bus.busy, bus.err} !== 4'b0001 || bus.arr_active !== '0) begin
      n_fail++; $display("FAIL timeout_abort: {seen_res,res_valid,busy,err} %b active %b expected 0001 / 0",
                         {seen_res, bus.res_valid, bus.busy, bus.err}, bus.arr_active);
    end
    arr_mode = 0;
  endtask

  task automatic test_len_bounds();
    int bad [2];
    bad[0] = 0;
    bad[1] = MAX_LEN + 1;
    for (int k = 0; k < 2; k++) begin
      bus.job_valid = 1'b1;
      bus.job_len   = LEN_W'(bad[k]);
      @(negedge clk);
      bus.job_valid = 1'b0;
      n_checks++;
      if ({bus.job_ready, bus.op_ready, bus.busy, bus.err} !== 4'b1001) begin
        n_fail++; $display("FAIL len_reject len=%0d: got %b expected 1001", bad[k],
                           {bus.job_ready, bus.op_ready, bus.busy, bus.err});
      end
      @(negedge clk);
      n_checks++;
      if ({bus.job_ready, bus.busy, bus.err} !== 3'b101) begin
        n_fail++; $display("FAIL len_stay_idle len=%0d: got %b expected 101", bad[k], {bus.job_ready, bus.busy, bus.err});
      end
      run_job(1, 1, 1'b0, 1'b0, '0, '0);
    end
    run_job(MAX_LEN, 1, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_back_to_back();
    repeat (6) run_job($urandom_range(1, 20), $urandom_range(1, 6), 1'($urandom), 1'b0, '0, '0);
  endtask

  task automatic test_reset_in_wait();
    bit seen;
    arr_mode = 2;
    bus.job_valid = 1'b1;
    bus.job_len   = LEN_W'(3);
    @(negedge clk);
    bus.job_valid = 1'b0;
    bus.op_valid  = 1'b1;
    bus.op_a      = NW'({$urandom, $urandom});
    bus.op_b      = NW'({$urandom, $urandom});
    @(negedge clk);
    bus.op_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL wait_busy: got %b expected 1", bus.busy);
    end
    #3 reset = 1'b0;
    #1;
    n_checks++;
    if ({bus.job_ready, bus.op_ready, bus.arr_start, bus.res_valid, bus.busy, bus.err} !== 6'b100000 ||
        bus.arr_active !== '0 || bus.arr_a !== '0 || bus.res_data !== '0) begin
      n_fail++; $display("FAIL async_reset: flags %b active %b arr_a %h data %h expected 100000 / 0 / 0 / 0",
                         {bus.job_ready, bus.op_ready, bus.arr_start, bus.res_valid, bus.busy, bus.err},
                         bus.arr_active, bus.arr_a, bus.res_data);
    end
    @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus.arr_start !== 1'b0 || bus.res_valid !== 1'b0 || bus.busy !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0 || bus.job_ready !== 1'b1) begin
      n_fail++; $display("FAIL post_reset_quiet: activity %b job_ready %b expected 0 / 1", seen, bus.job_ready);
    end
    arr_mode = 0;
  endtask

  initial begin
    bus.job_valid = 1'b0;
    bus.job_len   = '0;
    bus.op_valid  = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.res_ready = 1'b0;
    test_reset();
    test_single();
    test_multi_beat();
    test_backpressure();
    test_stale_ready();
    test_timeout();
    test_len_bounds();
    test_back_to_back();
    test_reset_in_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
